// File: rtl/dmem_host_responder.sv
// Data-memory responder for the RV32I core with a host command port.
// Define DMEM_HOST_DUMP_EN to enable READ responses on the host port.
module dmem_host_responder #(
  parameter int RAM_DEPTH = 64,
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ram_we,
  input  logic [AW-1:0]        ram_addr,
  input  logic [WORD_SIZE-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 core_en,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [1:0]           host_cmd,
  input  logic [AW-1:0]        host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic [CNT_WIDTH-1:0] run_cycles,
  output logic                 running
);

  typedef enum logic {HALT, RUN} state_t;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  logic [WORD_SIZE-1:0] mem [RAM_DEPTH];

  state_t state_q, state_d;
  logic   acc;
  logic   core_we;
  logic   host_we;
  logic   start;

  assign acc = host_valid && host_ready;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= HALT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      HALT: if (acc && host_cmd == CMD_RUN) begin
        state_d = RUN;
        start   = 1'b1;
      end
      RUN:  if (acc && host_cmd == CMD_HALT) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // core and host writes are exclusive by state; both are dropped on reset
  assign core_we = rst && state_q == RUN && ram_we;
  assign host_we = rst && state_q == HALT && acc
                   && host_cmd == CMD_WRITE;

  always_ff @(posedge clk) begin
    if (core_we)      mem[ram_addr]  <= ram_wdata;
    else if (host_we) mem[host_addr] <= host_wdata;
  end

  assign ram_rdata = mem[ram_addr];

  always_ff @(posedge clk) begin
    if (!rst)
      run_cycles <= '0;
    else if (start)
      run_cycles <= '0;
    else if (state_q == RUN && run_cycles != '1)
      run_cycles <= run_cycles + CNT_WIDTH'(1);
  end

  assign core_en = (state_q == RUN);
  assign running = (state_q == RUN);

`ifdef DMEM_HOST_DUMP_EN
  logic                 rvalid_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 rd_acc;

  assign rd_acc = state_q == HALT && acc && host_cmd == CMD_READ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[host_addr];
    end
  end

  assign host_ready  = ~rvalid_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
`else
  assign host_ready  = 1'b1;
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

endmodule

// File: tb/tb_dmem_host_responder.sv
// Randomized self-checking bench for dmem_host_responder.
// Two instances share stimulus: 32-bit and 4-bit run counters.
module tb_dmem_host_responder;

`ifdef DMEM_HOST_DUMP_EN
  localparam bit DUMP = 1'b1;
`else
  localparam bit DUMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        hvalid;
  logic [1:0]  hcmd;
  logic [5:0]  haddr;
  logic [31:0] hwdata;

  logic [31:0] ram_rdata, ram_rdata4;
  logic        core_en, core_en4;
  logic        hready, hready4;
  logic        hrvalid, hrvalid4;
  logic [31:0] hrdata, hrdata4;
  logic [31:0] run_cycles;
  logic [3:0]  run_cycles4;
  logic        running, running4;

  int pass_cnt = 0;
  int total = 0;

  logic [31:0] mmem [64];
  bit          mrun;
  int unsigned mcnt;
  bit          mrv;
  logic [31:0] mrd;

  always #5 clk = ~clk;

  dmem_host_responder dut (
    .clk(clk), .rst(rst_n),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .core_en(core_en),
    .host_valid(hvalid), .host_ready(hready),
    .host_cmd(hcmd), .host_addr(haddr),
    .host_wdata(hwdata),
    .host_rvalid(hrvalid), .host_rdata(hrdata),
    .run_cycles(run_cycles), .running(running)
  );

  dmem_host_responder #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst_n),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata4),
    .core_en(core_en4),
    .host_valid(hvalid), .host_ready(hready4),
    .host_cmd(hcmd), .host_addr(haddr),
    .host_wdata(hwdata),
    .host_rvalid(hrvalid4), .host_rdata(hrdata4),
    .run_cycles(run_cycles4), .running(running4)
  );

  // Reference behaviour, applied with the inputs seen at this edge
  function automatic void model_step();
    bit acc;
    acc = hvalid && !mrv;
    if (!rst_n) begin
      mrun = 0; mcnt = 0; mrv = 0; mrd = '0;
      return;
    end
    mrv = 0;
    if (mrun) begin
      if (ram_we) mmem[ram_addr] = ram_wdata;
      mcnt = mcnt + 1;
      if (acc && hcmd == 2'd2) mrun = 0;
    end else if (acc) begin
      case (hcmd)
        2'd0: mmem[haddr] = hwdata;
        2'd1: begin mrun = 1; mcnt = 0; end
        2'd3: if (DUMP) begin mrv = 1; mrd = mmem[haddr]; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [3:0] sat4(int unsigned c);
    return (c > 15) ? 4'hF : c[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    hvalid = 0; ram_we = 0; rst_n = 1;
  endtask

  task automatic cmd(input logic [1:0] c, input logic [5:0] a,
                     input logic [31:0] d);
    hvalid = 1; hcmd = c; haddr = a; hwdata = d;
    tick();
    hvalid = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    tick();
    rst_n = 1;
    total++;
    if (core_en !== 1'b0 || running !== 1'b0) $display(
      "FAIL reset_state core_en=%b running=%b want 0/0",
      core_en, running);
    else pass_cnt++;
    total++;
    if (run_cycles !== 32'd0 || hrvalid !== 1'b0 || hrdata !== 32'd0)
      $display("FAIL reset_outputs cnt=%0d rv=%b rd=%h want 0",
               run_cycles, hrvalid, hrdata);
    else pass_cnt++;
    total++;
    if (hready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", hready);
    else pass_cnt++;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 64; i++)
      cmd(2'd0, 6'(i), (i == 3) ? 32'hDEADBEEF : $urandom);
    for (int i = 0; i < 64; i++) begin
      ram_addr = 6'(i);
      #1;
      total++;
      if (ram_rdata !== mmem[i])
        $display("FAIL preload[%0d] got %h want %h",
                 i, ram_rdata, mmem[i]);
      else pass_cnt++;
    end
    ram_addr = 6'd3;
    #1;
    total++;
    if (ram_rdata !== 32'hDEADBEEF || core_en !== 1'b0
        || run_cycles !== 32'd0)
      $display("FAIL write_addr3 rd=%h en=%b cnt=%0d want deadbeef/0/0",
               ram_rdata, core_en, run_cycles);
    else pass_cnt++;
  endtask

  task automatic test_core_store();
    logic [31:0] old5;
    old5 = mmem[5];
    ram_we = 1; ram_addr = 6'd5; ram_wdata = 32'h1234;
    tick();
    ram_we = 0;
    #1;
    total++;
    if (ram_rdata !== old5)
      $display("FAIL halt_store got %h want %h", ram_rdata, old5);
    else pass_cnt++;
    cmd(2'd1, 6'd0, 32'd0);
    ram_we = 1; ram_addr = 6'd5; ram_wdata = 32'h1234;
    tick();
    ram_we = 0;
    #1;
    total++;
    if (ram_rdata !== 32'h00001234)
      $display("FAIL run_store got %h want 00001234", ram_rdata);
    else pass_cnt++;
    cmd(2'd2, 6'd0, 32'd0);
  endtask

  task automatic test_run_count();
    cmd(2'd1, 6'd0, 32'd0);
    total++;
    if (core_en !== 1'b1 || running !== 1'b1 || run_cycles !== 32'd0)
      $display("FAIL run_start en=%b run=%b cnt=%0d want 1/1/0",
               core_en, running, run_cycles);
    else pass_cnt++;
    repeat (10) tick();
    hvalid = 1; hcmd = 2'd2;
    #3;
    total++;
    if (core_en !== 1'b1)
      $display("FAIL halt_comb core_en=%b want 1", core_en);
    else pass_cnt++;
    tick();
    hvalid = 0;
    total++;
    if (core_en !== 1'b0 || run_cycles !== 32'd11)
      $display("FAIL halt_count en=%b cnt=%0d want 0/11",
               core_en, run_cycles);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (run_cycles !== 32'd11)
      $display("FAIL halt_hold cnt=%0d want 11", run_cycles);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    cmd(2'd1, 6'd0, 32'd0);
    repeat (20) tick();
    total++;
    if (run_cycles4 !== 4'hF || run_cycles !== mcnt)
      $display("FAIL saturate cnt4=%h cnt=%0d want f/%0d",
               run_cycles4, run_cycles, mcnt);
    else pass_cnt++;
    cmd(2'd1, 6'd0, 32'd0);
    total++;
    if (run_cycles4 !== 4'hF)
      $display("FAIL run_in_run cnt4=%h want f", run_cycles4);
    else pass_cnt++;
    cmd(2'd2, 6'd0, 32'd0);
    cmd(2'd1, 6'd0, 32'd0);
    total++;
    if (run_cycles4 !== 4'h0 || run_cycles !== 32'd0)
      $display("FAIL restart cnt4=%h cnt=%0d want 0/0",
               run_cycles4, run_cycles);
    else pass_cnt++;
  endtask

  task automatic test_run_host_drop();
    logic [31:0] old7;
    old7 = mmem[7];
    cmd(2'd0, 6'd7, 32'hAAAA);
    cmd(2'd3, 6'd7, 32'd0);
    ram_addr = 6'd7;
    #1;
    total++;
    if (ram_rdata !== old7 || hrvalid !== 1'b0)
      $display("FAIL run_drop rd=%h rv=%b want %h/0",
               ram_rdata, hrvalid, old7);
    else pass_cnt++;
    ram_we = 1; ram_addr = 6'd9; ram_wdata = 32'hCAFE0009;
    rst_n = 0;
    tick();
    idle();
    ram_addr = 6'd9;
    #1;
    total++;
    if (core_en !== 1'b0 || running !== 1'b0 || ram_rdata !== mmem[9])
      $display("FAIL mid_reset en=%b run=%b rd=%h want 0/0/%h",
               core_en, running, ram_rdata, mmem[9]);
    else pass_cnt++;
    ram_addr = 6'd3;
    #1;
    total++;
    if (ram_rdata !== 32'hDEADBEEF)
      $display("FAIL reset_keep got %h want deadbeef", ram_rdata);
    else pass_cnt++;
  endtask

  task automatic test_read();
    hvalid = 1; hcmd = 2'd3; haddr = 6'd3;
    tick();
    hvalid = 1; hcmd = 2'd0; haddr = 6'd3; hwdata = 32'h0BADF00D;
    total++;
    if (hrvalid !== (DUMP ? 1'b1 : 1'b0)
        || hrdata !== (DUMP ? 32'hDEADBEEF : 32'h0)
        || hready !== (DUMP ? 1'b0 : 1'b1))
      $display("FAIL read_resp rv=%b rd=%h rdy=%b want %b/%h/%b",
               hrvalid, hrdata, hready, DUMP,
               DUMP ? 32'hDEADBEEF : 32'h0, !DUMP);
    else pass_cnt++;
    while (!(hvalid && !mrv)) tick();
    tick();
    hvalid = 0;
    total++;
    if (hrvalid !== 1'b0 || hready !== 1'b1)
      $display("FAIL read_done rv=%b rdy=%b want 0/1", hrvalid, hready);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      if (!(hvalid && mrv)) begin
        hvalid = ($urandom_range(0, 2) == 0);
        hcmd   = 2'($urandom);
        haddr  = 6'($urandom);
        hwdata = $urandom;
      end
      ram_we    = $urandom_range(0, 1) == 1;
      ram_addr  = 6'($urandom);
      ram_wdata = $urandom;
      rst_n     = ($urandom_range(0, 60) != 0);
      #1;
      total++;
      if (ram_rdata !== mmem[ram_addr])
        $display("FAIL rnd_rdata n=%0d got %h want %h",
                 n, ram_rdata, mmem[ram_addr]);
      else pass_cnt++;
      tick();
      total++;
      if (core_en !== mrun || running !== mrun
          || run_cycles !== mcnt || run_cycles4 !== sat4(mcnt))
        $display("FAIL rnd_ctrl n=%0d en=%b cnt=%0d cnt4=%h want %b/%0d/%h",
                 n, core_en, run_cycles, run_cycles4,
                 mrun, mcnt, sat4(mcnt));
      else pass_cnt++;
      total++;
      if (hready !== !mrv || hrvalid !== mrv || hrdata !== mrd)
        $display("FAIL rnd_host n=%0d rdy=%b rv=%b rd=%h want %b/%b/%h",
                 n, hready, hrvalid, hrdata, !mrv, mrv, mrd);
      else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    idle();
    hcmd = 0; haddr = 0; hwdata = 0;
    ram_addr = 0; ram_wdata = 0;
    mrun = 0; mcnt = 0; mrv = 0; mrd = '0;
    test_reset();
    test_preload();
    test_core_store();
    test_run_count();
    test_saturation();
    test_run_host_drop();
    test_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/dmem_host_responder.md
Name: dmem_host_responder

Overview:
- Data-memory responder for the single-cycle RV32I core's data port: takes the core's RAM write-enable, word address and store data, and returns read data in the same cycle.
- Adds a host-side command port with a valid/ready handshake to preload memory, start and stop the core, and count run cycles.
- Drives the core's PC-register enable (core_en), so the core only advances while this block is in RUN.

Parameters:
- RAM_DEPTH, 64, number of words; address width is $clog2(RAM_DEPTH).
- WORD_SIZE, 32, data word width in bits.
- CNT_WIDTH, 32, width of the run-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ram_we  in  1  core store enable.
- ram_addr  in  $clog2(RAM_DEPTH)  core word address.
- ram_wdata  in  WORD_SIZE  core store data.
- ram_rdata  out  WORD_SIZE  load data to core.
- core_en  out  1  core PC-register enable.
- host_valid  in  1  host command valid.
- host_ready  out  1  block can accept a command.
- host_cmd  in  2  00=WRITE, 01=RUN, 10=HALT, 11=READ.
- host_addr  in  $clog2(RAM_DEPTH)  host word address.
- host_wdata  in  WORD_SIZE  host write data.
- host_rvalid  out  1  read response valid.
- host_rdata  out  WORD_SIZE  read response data.
- run_cycles  out  CNT_WIDTH  cycles spent in RUN since the last RUN command.
- running  out  1  state==RUN.

Behaviour:
- Storage: RAM_DEPTH x WORD_SIZE array; contents are not cleared by reset.
- Core reads: ram_rdata = mem[ram_addr], combinational, valid in every state.
- Core writes: mem[ram_addr] <= ram_wdata on a clk edge with ram_we=1 and state==RUN. ram_we is ignored in HALT.
- Reset (rst=0 at an edge):
  - state=HALT, core_en=0, running=0.
  - run_cycles=0, host_rvalid=0, host_rdata=0.
  - host_ready=1 from the first cycle after reset.
  - Reset mid-RUN stops the core at that edge. A core write presented on the reset edge is dropped.
- Handshake:
  - A command is accepted on an edge where host_valid && host_ready.
  - Host holds cmd/addr/wdata stable until accepted.
  - host_ready is 1 except during the READ response cycle.
- FSM states: HALT, RUN.
  - HALT + WRITE accepted: mem[host_addr] <= host_wdata at that edge.
  - HALT + RUN accepted: next cycle state=RUN, core_en=1, running=1, run_cycles=0.
  - HALT + HALT accepted: no effect.
  - RUN + HALT accepted: next cycle state=HALT, core_en=0. A core write on the accepting edge still completes. run_cycles holds its value.
  - RUN + WRITE or READ accepted: command is dropped, memory is unchanged, no response is generated. This prevents contention with the core.
  - RUN + RUN accepted: no effect (the counter is not cleared).
- run_cycles: increments by 1 on every edge where state==RUN. It saturates at all-ones and does not wrap. It is cleared only on HALT->RUN or by reset.
- core_en is registered: equal to (state==RUN), no combinational path from host inputs.
- Address width: host_addr and ram_addr are exactly $clog2(RAM_DEPTH) bits, so there is no out-of-range case.

Optional Feature:
- Macro: DMEM_HOST_DUMP_EN.
- Defined:
  - HALT + READ accepted: on the next cycle host_rvalid=1 for exactly one cycle, with host_rdata = mem[host_addr] sampled at the accepting edge.
  - host_ready=0 during that response cycle.
  - A WRITE to the same address on the cycle after the READ is not reflected in the response already issued.
- Undefined:
  - READ is accepted and ignored.
  - host_rvalid and host_rdata are constant 0.
  - host_ready is never deasserted by READ.

Test Plan:
- Reset then WRITE addr 3 = 0xDEADBEEF while in HALT -> ram_addr=3 gives ram_rdata=0xDEADBEEF, core_en=0, run_cycles=0.
- HALT with ram_we=1, ram_addr=5, ram_wdata=0x1234 -> mem[5] unchanged. RUN accepted, then ram_we=1, addr 5, data 0x1234 one cycle later -> ram_rdata=0x00001234.
- RUN accepted, 10 cycles, HALT accepted -> core_en falls the cycle after acceptance; run_cycles=11 (counts the HALT-accept edge) and stays constant.
- CNT_WIDTH=4, RUN for 20 cycles -> run_cycles=4'hF and holds; a new HALT then RUN clears it to 0.
- In RUN, WRITE addr 7 = 0xAAAA -> mem[7] unchanged. rst=0 for one edge mid-RUN -> core_en=0, running=0, mem contents preserved.
- DMEM_HOST_DUMP_EN: READ addr 3 in HALT -> host_rvalid=1 next cycle with host_rdata=0xDEADBEEF and host_ready=0 that cycle. Without the macro -> host_rvalid stays 0.
